// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: ALU op encodings, bundle width defaults, flag indices and forwarding helper
package ex_stage_pkg;
  localparam int WB_SIZE = 4;
  localparam int MEM_SIZE = 6;
  localparam int EX_SIZE = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;
  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_ADD = 3'b001,
    OP_SUB = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_NOT = 3'b101,
    OP_INC = 3'b110,
    OP_MOV = 3'b111
  } alu_op_e;
  function automatic logic [15:0] fwd_sel(
    input logic [2:0] src,
    input logic [15:0] rf,
    input logic mem_we,
    input logic [2:0] mem_rd,
    input logic [15:0] mem_v,
    input logic wb_we,
    input logic [2:0] wb_rd,
    input logic [15:0] wb_v
  );
    return (mem_we && mem_rd == src) ? mem_v : (wb_we && wb_rd == src) ? wb_v : rf;
  endfunction
endpackage

// File: rtl/ex_stage_alu_core.sv
// alu_core: 16-bit ALU producing result and C/N/Z from operands, op and current carry
module alu_core
  import ex_stage_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  alu_op_e     op,
  input  logic        c_in,
  output logic [15:0] result,
  output logic        c,
  output logic        n,
  output logic        z
);
  logic [16:0] sum, inc;
  assign sum = {1'b0, a} + {1'b0, b};
  assign inc = {1'b0, a} + 17'd1;
  always_comb begin
    result = a;
    c = c_in;
    case (op)
      OP_ADD: {c, result} = sum;
      OP_SUB: begin
        result = a - b;
        c = a < b;
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_NOT: result = ~a;
      OP_INC: {c, result} = inc;
      OP_MOV: result = b;
      default: ;
    endcase
  end
  assign n = result[15];
  assign z = result == 16'd0;
endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage with operand forwarding, ALU, CCR with shadow save/restore, EX/MEM register
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int WbSize = WB_SIZE,
  parameter int MemSize = MEM_SIZE,
  parameter int ExSize = EX_SIZE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               flush,
  input  logic [WbSize-1:0]  i_WB,
  input  logic [MemSize-1:0] i_Mem,
  input  logic [ExSize-1:0]  i_Ex,
  input  logic               i_chg_flag,
  input  logic               i_immd_sel,
  input  logic [31:0]        i_pc,
  input  logic [2:0]         i_Rsrc1,
  input  logic [2:0]         i_Rsrc2,
  input  logic [2:0]         i_Rdst,
  input  logic [15:0]        i_immd,
  input  logic [15:0]        i_read_data1,
  input  logic [15:0]        i_read_data2,
  input  logic               mem_regwrite,
  input  logic [2:0]         mem_rdst,
  input  logic [15:0]        mem_result,
  input  logic               wb_regwrite,
  input  logic [2:0]         wb_rdst,
  input  logic [15:0]        wb_data,
  input  logic               flag_save,
  input  logic               flag_restore,
  output logic [WbSize-1:0]  o_WB,
  output logic [MemSize-1:0] o_Mem,
  output logic [15:0]        o_result,
  output logic [15:0]        o_store_data,
  output logic [2:0]         o_Rdst,
  output logic [31:0]        o_pc,
  output logic [2:0]         o_flags
);
  logic [15:0] op_a, op_r2, op_b, alu_res;
  logic [2:0] ccr, shadow, alu_flags;
  logic upd;
  alu_op_e op;
  assign op = alu_op_e'(i_Ex[2:0]);
  assign op_a = fwd_sel(i_Rsrc1, i_read_data1, mem_regwrite, mem_rdst, mem_result, wb_regwrite, wb_rdst, wb_data);
  assign op_r2 = fwd_sel(i_Rsrc2, i_read_data2, mem_regwrite, mem_rdst, mem_result, wb_regwrite, wb_rdst, wb_data);
  assign op_b = i_immd_sel ? i_immd : op_r2;
  alu_core u_alu (
    .a(op_a),
    .b(op_b),
    .op(op),
    .c_in(ccr[FLAG_C]),
    .result(alu_res),
    .c(alu_flags[FLAG_C]),
    .n(alu_flags[FLAG_N]),
    .z(alu_flags[FLAG_Z])
  );
  assign upd = enable && !flush && i_chg_flag && op != OP_NOP;
  assign o_flags = ccr;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_WB <= '0;
      o_Mem <= '0;
      o_result <= '0;
      o_store_data <= '0;
      o_Rdst <= '0;
      o_pc <= '0;
      ccr <= '0;
      shadow <= '0;
    end else begin
      if (flush) begin
        o_WB <= '0;
        o_Mem <= '0;
      end else if (enable) begin
        o_WB <= i_WB;
        o_Mem <= i_Mem;
        o_result <= alu_res;
        o_store_data <= op_r2;
        o_Rdst <= i_Rdst;
        o_pc <= i_pc;
      end
      // restore beats the ALU; save reads the pre-edge CCR, so save+restore swaps
      if (flag_restore) ccr <= shadow;
      else if (upd) ccr <= alu_flags;
      if (flag_save) shadow <= ccr;
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: randomized scoreboard bench for ex_stage against a behavioural model
module tb_ex_stage;
  logic clk, rst, enable, flush, i_chg_flag, i_immd_sel;
  logic [3:0] i_WB;
  logic [5:0] i_Mem;
  logic [2:0] i_Ex, i_Rsrc1, i_Rsrc2, i_Rdst, mem_rdst, wb_rdst;
  logic [31:0] i_pc;
  logic [15:0] i_immd, i_read_data1, i_read_data2, mem_result, wb_data;
  logic mem_regwrite, wb_regwrite, flag_save, flag_restore;
  logic [3:0] o_WB;
  logic [5:0] o_Mem;
  logic [15:0] o_result, o_store_data;
  logic [2:0] o_Rdst, o_flags;
  logic [31:0] o_pc;
  typedef struct {
    logic [3:0] wb;
    logic [5:0] mem;
    logic [15:0] res, st;
    logic [2:0] rdst, flags;
    logic [31:0] pc;
  } exp_t;
  exp_t sb[$];
  exp_t m;
  logic [2:0] m_sh;
  int errors = 0, checks = 0;
  ex_stage dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush), .i_WB(i_WB), .i_Mem(i_Mem), .i_Ex(i_Ex),
    .i_chg_flag(i_chg_flag), .i_immd_sel(i_immd_sel), .i_pc(i_pc), .i_Rsrc1(i_Rsrc1), .i_Rsrc2(i_Rsrc2),
    .i_Rdst(i_Rdst), .i_immd(i_immd), .i_read_data1(i_read_data1), .i_read_data2(i_read_data2),
    .mem_regwrite(mem_regwrite), .mem_rdst(mem_rdst), .mem_result(mem_result), .wb_regwrite(wb_regwrite),
    .wb_rdst(wb_rdst), .wb_data(wb_data), .flag_save(flag_save), .flag_restore(flag_restore),
    .o_WB(o_WB), .o_Mem(o_Mem), .o_result(o_result), .o_store_data(o_store_data), .o_Rdst(o_Rdst),
    .o_pc(o_pc), .o_flags(o_flags)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_all(input exp_t e);
    chk("o_WB", 32'(o_WB), 32'(e.wb));
    chk("o_Mem", 32'(o_Mem), 32'(e.mem));
    chk("o_result", 32'(o_result), 32'(e.res));
    chk("o_store_data", 32'(o_store_data), 32'(e.st));
    chk("o_Rdst", 32'(o_Rdst), 32'(e.rdst));
    chk("o_pc", o_pc, e.pc);
    chk("o_flags", 32'(o_flags), 32'(e.flags));
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && sb.size() > 0) begin
        e = sb.pop_front();
        chk_all(e);
      end
    end
  end
  function automatic logic [15:0] pick(input logic [2:0] src, input logic [15:0] rf);
    if (mem_regwrite && mem_rdst == src) return mem_result;
    if (wb_regwrite && wb_rdst == src) return wb_data;
    return rf;
  endfunction
  // Model: compute the next visible state from the current inputs, then push it.
  task automatic cycle();
    int a, r2, b, t;
    logic [15:0] res;
    logic c;
    logic [2:0] old_ccr;
    a = int'(pick(i_Rsrc1, i_read_data1));
    r2 = int'(pick(i_Rsrc2, i_read_data2));
    b = i_immd_sel ? int'(i_immd) : r2;
    c = m.flags[2];
    t = a;
    case (i_Ex)
      3'd1: begin t = a + b; c = t > 65535; end
      3'd2: begin t = a - b; c = a < b; end
      3'd3: t = a & b;
      3'd4: t = a | b;
      3'd5: t = 65535 - a;
      3'd6: begin t = a + 1; c = t > 65535; end
      3'd7: t = b;
      default: t = a;
    endcase
    res = 16'(t);
    old_ccr = m.flags;
    if (flag_restore) m.flags = m_sh;
    else if (enable && !flush && i_chg_flag && i_Ex != 3'd0) m.flags = {c, res[15], res == 16'd0};
    if (flag_save) m_sh = old_ccr;
    if (flush) begin
      m.wb = 0;
      m.mem = 0;
    end else if (enable) begin
      m.wb = i_WB;
      m.mem = i_Mem;
      m.res = res;
      m.st = 16'(r2);
      m.rdst = i_Rdst;
      m.pc = i_pc;
    end
    sb.push_back(m);
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic idle();
    enable = 1; flush = 0; i_WB = 4'h5; i_Mem = 6'h2A; i_Ex = 0; i_chg_flag = 0; i_immd_sel = 0;
    i_pc = 32'h100; i_Rsrc1 = 1; i_Rsrc2 = 2; i_Rdst = 4; i_immd = 0; i_read_data1 = 0;
    i_read_data2 = 0; mem_regwrite = 0; mem_rdst = 0; mem_result = 0; wb_regwrite = 0;
    wb_rdst = 0; wb_data = 0; flag_save = 0; flag_restore = 0;
  endtask
  task automatic rand_in();
    enable = $urandom_range(0, 9) != 0;
    flush = $urandom_range(0, 9) == 0;
    i_WB = 4'($urandom); i_Mem = 6'($urandom); i_Ex = 3'($urandom);
    i_chg_flag = 1'($urandom); i_immd_sel = 1'($urandom); i_pc = $urandom;
    i_Rsrc1 = 3'($urandom); i_Rsrc2 = 3'($urandom); i_Rdst = 3'($urandom);
    i_immd = $urandom_range(0, 3) == 0 ? 16'hFFFF : 16'($urandom);
    i_read_data1 = $urandom_range(0, 3) == 0 ? 16'hFFFF : 16'($urandom);
    i_read_data2 = 16'($urandom);
    mem_regwrite = 1'($urandom); mem_rdst = 3'($urandom); mem_result = 16'($urandom);
    wb_regwrite = 1'($urandom); wb_rdst = 3'($urandom); wb_data = 16'($urandom);
    flag_save = $urandom_range(0, 11) == 0;
    flag_restore = $urandom_range(0, 11) == 0;
  endtask
  initial begin
    m = '{wb: 0, mem: 0, res: 0, st: 0, rdst: 0, flags: 0, pc: 0};
    m_sh = 0;
    idle();
    rst = 1;
    #3;
    chk_all(m);
    @(negedge clk);
    @(negedge clk);
    chk_all(m);
    rst = 0;
    idle(); i_Ex = 3'd1; i_read_data1 = 16'hFFFF; i_immd_sel = 1; i_immd = 16'h0001; i_chg_flag = 1;
    cycle();
    chk("add_wrap_result", 32'(o_result), 32'h0);
    chk("add_wrap_flags", 32'(o_flags), 32'b101);
    idle(); i_Ex = 3'd2; i_read_data1 = 16'h0003; i_immd_sel = 1; i_immd = 16'h0005; i_chg_flag = 1;
    cycle();
    chk("sub_borrow_result", 32'(o_result), 32'hFFFE);
    chk("sub_borrow_flags", 32'(o_flags), 32'b110);
    idle(); i_Ex = 3'd7; i_Rsrc1 = 3; i_Rsrc2 = 3; mem_rdst = 3; wb_rdst = 3; mem_regwrite = 1;
    wb_regwrite = 1; mem_result = 16'h1111; wb_data = 16'h2222; i_read_data1 = 16'h3333; i_read_data2 = 16'h4444;
    cycle();
    chk("fwd_priority", 32'(o_result), 32'h1111);
    idle(); i_Ex = 3'd1; i_WB = 4'hF; i_Mem = 6'h3F; i_read_data1 = 16'h0010; i_read_data2 = 16'h0020;
    i_chg_flag = 1; flush = 1;
    cycle();
    chk("flush_wb", 32'(o_WB), 32'h0);
    chk("flush_mem", 32'(o_Mem), 32'h0);
    chk("flush_hold_result", 32'(o_result), 32'h1111);
    chk("flush_ccr", 32'(o_flags), 32'b110);
    flush = 0; enable = 0; i_WB = 4'h9; i_pc = 32'hDEAD;
    cycle();
    chk("hold_wb", 32'(o_WB), 32'h0);
    chk("hold_pc", o_pc, 32'h100);
    idle(); i_Ex = 3'd1; i_read_data1 = 16'h7FFF; i_immd_sel = 1; i_immd = 16'h0001; i_chg_flag = 1;
    cycle();
    chk("ccr_before_save", 32'(o_flags), 32'b010);
    idle(); flag_save = 1;
    cycle();
    idle(); i_Ex = 3'd2; i_read_data1 = 16'h0003; i_immd_sel = 1; i_immd = 16'h0005; i_chg_flag = 1;
    cycle();
    chk("ccr_after_sub", 32'(o_flags), 32'b110);
    idle(); i_Ex = 3'd1; i_read_data1 = 16'hFFFF; i_immd_sel = 1; i_immd = 16'h0001; i_chg_flag = 1;
    flag_restore = 1;
    cycle();
    chk("restore_priority", 32'(o_flags), 32'b010);
    for (int i = 0; i < 400; i++) begin
      rand_in();
      cycle();
    end
    idle(); i_Ex = 3'd7; i_immd_sel = 1; i_immd = 16'hABCD;
    cycle();
    chk("pre_reset_result", 32'(o_result), 32'hABCD);
    enable = 0;
    @(posedge clk);
    #3;
    rst = 1;
    #1;
    chk("async_rst_result", 32'(o_result), 32'h0);
    chk("async_rst_flags", 32'(o_flags), 32'h0);
    m = '{wb: 0, mem: 0, res: 0, st: 0, rdst: 0, flags: 0, pc: 0};
    m_sh = 0;
    chk_all(m);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 60; i++) begin
      rand_in();
      cycle();
    end
    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
